// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a 4-bit universal shift register: load, then N rotate/shift steps.
// Optional macro SEQ_SOUT_CAPTURE_EN adds sout_bits, the serial-out stream seen during RUN.
module shift_reg_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_sin,
    output logic             reg_enb,
    output logic             reg_dir,
    output logic [1:0]       reg_modo,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_sin,
    input  logic [WIDTH-1:0] reg_q,
    input  logic             reg_sout,
    output logic             done,
`ifdef SEQ_SOUT_CAPTURE_EN
    output logic [WIDTH-1:0] sout_bits,
`endif
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         op_q;
    logic               dir_q;
    logic               sin_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               rot_q;
    logic               shf_q;

    assign cmd_ready = (state == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign rot_q     = (op_q == 2'b01);
    assign shf_q     = (op_q == 2'b10);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and Moore decode of the register controls
    always_comb begin
        state_nxt = state;
        reg_enb   = 1'b0;
        reg_dir   = 1'b0;
        reg_modo  = 2'b00;
        reg_d     = '0;
        reg_sin   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = LOAD;
            end
            LOAD: begin
                reg_enb  = 1'b1;
                reg_modo = 2'b10;
                reg_d    = data_q;
                if ((!rot_q && !shf_q) || (cnt == '0)) state_nxt = CAPTURE;
                else                                   state_nxt = RUN;
            end
            RUN: begin
                reg_enb  = 1'b1;
                reg_dir  = dir_q;
                reg_sin  = shf_q && sin_q;
                reg_modo = rot_q ? 2'b01 : 2'b00;
                if (cnt == CNT_W'(1)) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the command at handshake; count down the steps while running
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 2'b00;
            dir_q  <= 1'b0;
            sin_q  <= 1'b0;
            data_q <= '0;
            cnt    <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            dir_q  <= cmd_dir;
            sin_q  <= cmd_sin;
            data_q <= cmd_data;
            cnt    <= cmd_amt;
        end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Capture the final register value and pulse done once
    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= (state == CAPTURE);
            if (state == CAPTURE) result <= reg_q;
        end
    end

`ifdef SEQ_SOUT_CAPTURE_EN
    // Collect the serial-out bit of every RUN step, newest in the LSB
    always_ff @(posedge clk) begin
        if (reset || accept) sout_bits <= '0;
        else if (state == RUN) sout_bits <= {sout_bits[WIDTH-2:0], reg_sout};
    end
`else
    logic unused_sout;
    assign unused_sout = reg_sout;
`endif

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: external register model, cycle-level expectation model,
// per-cycle compare plus directed scenarios with hand-computed results.
module tb_shift_reg_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic       cmd_dir = 1'b0;
    logic [2:0] cmd_amt = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic       cmd_sin = 1'b0;
    logic       reg_enb;
    logic       reg_dir;
    logic [1:0] reg_modo;
    logic [3:0] reg_d;
    logic       reg_sin;
    logic [3:0] reg_q;
    logic       reg_sout;
    logic       done;
    logic [3:0] result;
`ifdef SEQ_SOUT_CAPTURE_EN
    logic [3:0] sout_bits;
`endif

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    shift_reg_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_dir(cmd_dir),
        .cmd_amt(cmd_amt),
        .cmd_data(cmd_data),
        .cmd_sin(cmd_sin),
        .reg_enb(reg_enb),
        .reg_dir(reg_dir),
        .reg_modo(reg_modo),
        .reg_d(reg_d),
        .reg_sin(reg_sin),
        .reg_q(reg_q),
        .reg_sout(reg_sout),
        .done(done),
`ifdef SEQ_SOUT_CAPTURE_EN
        .sout_bits(sout_bits),
`endif
        .result(result)
    );

    // External 4-bit universal shift register
    logic [3:0] q_r = 4'd0;
    always @(posedge clk) begin
        if (reg_enb) begin
            case (reg_modo)
                2'b10: q_r <= reg_d;
                2'b01: q_r <= reg_dir ? {q_r[2:0], q_r[3]} : {q_r[0], q_r[3:1]};
                2'b00: q_r <= reg_dir ? {q_r[2:0], reg_sin} : {reg_sin, q_r[3:1]};
                default: ;
            endcase
        end
    end
    assign reg_q    = q_r;
    assign reg_sout = reg_dir ? q_r[3] : q_r[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic result of a command
    function automatic logic [3:0] expect_q(input logic [1:0] op, input logic dir,
                                            input logic [2:0] amt, input logic [3:0] d,
                                            input logic sin);
        int v, n, r, fill;
        v = int'(d);
        n = int'(amt);
        if (op == 2'b01) begin
            r = n % 4;
            if (dir) v = (v << r) | (v >> (4 - r));
            else     v = (v >> r) | (v << (4 - r));
        end else if (op == 2'b10) begin
            if (n >= 4) v = sin ? 15 : 0;
            else if (dir) begin
                fill = sin ? ((1 << n) - 1) : 0;
                v = (v << n) | fill;
            end else begin
                fill = sin ? ((15 << (4 - n)) & 15) : 0;
                v = (v >> n) | fill;
            end
        end
        return 4'(v & 15);
    endfunction

    // Cycle-level expectation model: k counts cycles since the handshake
    bit         started = 1'b0;
    bit         m_active = 1'b0;
    bit         m_done = 1'b0;
    int         m_k = 0;
    int         m_eff = 0;
    logic [1:0] m_op = 2'b00;
    logic       m_dir = 1'b0;
    logic [2:0] m_amt = 3'd0;
    logic [3:0] m_data = 4'd0;
    logic       m_sin = 1'b0;
    logic [3:0] m_res = 4'd0;

    always @(posedge clk) begin
        if (reset) begin
            started  = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_res    = 4'd0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (cmd_valid && started) begin
                m_op     = cmd_op;
                m_dir    = cmd_dir;
                m_amt    = cmd_amt;
                m_data   = cmd_data;
                m_sin    = cmd_sin;
                m_eff    = (cmd_op == 2'b01 || cmd_op == 2'b10) ? int'(cmd_amt) : 0;
                m_active = 1'b1;
                m_k      = 1;
            end
        end else begin
            m_k++;
            if (m_k == m_eff + 3) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_res    = expect_q(m_op, m_dir, m_amt, m_data, m_sin);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        bit         ld, rn;
        logic [1:0] e_modo;
        if (started) begin
            ld = m_active && (m_k == 1);
            rn = m_active && (m_k >= 2) && (m_k <= m_eff + 1);
            e_modo = ld ? 2'b10 : ((rn && m_op == 2'b01) ? 2'b01 : 2'b00);
            chk("cmd_ready", 32'(cmd_ready), 32'(!reset && !m_active));
            chk("reg_enb", 32'(reg_enb), 32'(ld || rn));
            chk("reg_modo", 32'(reg_modo), 32'(e_modo));
            chk("reg_d", 32'(reg_d), ld ? 32'(m_data) : 32'd0);
            chk("reg_dir", 32'(reg_dir), rn ? 32'(m_dir) : 32'd0);
            chk("reg_sin", 32'(reg_sin), (rn && m_op == 2'b10) ? 32'(m_sin) : 32'd0);
            chk("done", 32'(done), 32'(m_done));
            chk("result", 32'(result), 32'(m_res));
        end
    end

    // Offer a command and return 2 time units after the accepting edge
    task automatic issue(input logic [1:0] op, input logic dir, input logic [2:0] amt,
                         input logic [3:0] data, input logic sin);
        int w;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_amt   = amt;
        cmd_data  = data;
        cmd_sin   = sin;
        cmd_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) chk("handshake_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #2;
    endtask

    // Count negedges until done; lat starts at the given cycle number
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic dir,
                       input logic [2:0] amt, input logic [3:0] data, input logic sin,
                       input int exp_lat, input logic [3:0] exp_res);
        int lat;
        issue(op, dir, amt, data, sin);
        cmd_valid = 1'b0;
        wait_done(0, lat);
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_result"}, 32'(result), 32'(exp_res));
        chk({name, "_model"}, 32'(expect_q(op, dir, amt, data, sin)), 32'(exp_res));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dones;

        // Reset
        @(negedge clk);
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);
        chk("result_after_reset", 32'(result), 32'd0);
        chk("enb_after_reset", 32'(reg_enb), 32'd0);

        // Load only, with LOAD-cycle controls checked directly
        issue(2'b00, 1'b0, 3'd0, 4'b0101, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("load_modo", 32'(reg_modo), 32'h2);
        chk("load_d", 32'(reg_d), 32'h5);
        chk("load_enb", 32'(reg_enb), 32'd1);
        wait_done(1, lat);
        chk("load_latency", 32'(lat), 32'd3);
        chk("load_result", 32'(result), 32'h5);

        run("rotl1", 2'b01, 1'b1, 3'd1, 4'b0001, 1'b0, 4, 4'b0010);
        run("rotr5", 2'b01, 1'b0, 3'd5, 4'b0001, 1'b0, 8, 4'b1000);
        run("shl2s1", 2'b10, 1'b1, 3'd2, 4'b0001, 1'b1, 5, 4'b0111);

        // Busy with cmd_valid held, then back-to-back at done
        issue(2'b01, 1'b1, 3'd3, 4'b0011, 1'b0);
        cmd_op   = 2'b10;
        cmd_dir  = 1'b0;
        cmd_amt  = 3'd1;
        cmd_data = 4'b1000;
        cmd_sin  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("busy_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_first_result", 32'(result), 32'b1001);
        @(posedge clk);
        #2 cmd_valid = 1'b0;
        @(negedge clk);
        chk("b2b_load_modo", 32'(reg_modo), 32'h2);
        chk("b2b_load_d", 32'(reg_d), 32'b1000);
        wait_done(1, lat);
        chk("b2b_latency", 32'(lat), 32'd4);
        chk("b2b_result", 32'(result), 32'b1100);

        // Mid-run reset after a zero result
        run("zero", 2'b00, 1'b0, 3'd0, 4'b0000, 1'b0, 3, 4'b0000);
        issue(2'b01, 1'b1, 3'd4, 4'b0110, 1'b0);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("midrst_enb", 32'(reg_enb), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            if (done) dones++;
            @(negedge clk);
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);

        // Boundaries: reserved op, zero steps, maximum steps
        run("reserved", 2'b11, 1'b0, 3'd0, 4'b1010, 1'b0, 3, 4'b1010);
        run("rot_amt0", 2'b01, 1'b1, 3'd0, 4'b0110, 1'b0, 3, 4'b0110);
        run("shr7", 2'b10, 1'b0, 3'd7, 4'b1111, 1'b0, 10, 4'b0000);
        run("rotl7", 2'b01, 1'b1, 3'd7, 4'b1001, 1'b0, 10, 4'b1100);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
